// File: rtl/clock_set_controller.sv
// Three-button hour/min/sec edit sequencer feeding a Clock load port.
// Button edges act one cycle after the level rises; set pulses for the single COMMIT cycle.
module clock_set_controller #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int HOUR_MAX       = 23
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic [5:0] cur_sec,
   input  logic [5:0] cur_min,
   input  logic [4:0] cur_hour,
   output logic       set,
   output logic [5:0] sec_in,
   output logic [5:0] min_in,
   output logic [4:0] hour_in,
   output logic       editing,
   output logic [1:0] field_sel
);

   localparam int          LP_CW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [LP_CW-1:0] LP_CNT_LAST = LP_CW'(TIMEOUT_CYCLES - 1);
   localparam logic [4:0]  LP_HOUR_MAX  = 5'(HOUR_MAX);
   localparam logic [5:0]  LP_MS_MAX    = 6'd59;

   typedef enum logic [2:0] {
      ST_RUN       = 3'd0,
      ST_EDIT_HOUR = 3'd1,
      ST_EDIT_MIN  = 3'd2,
      ST_EDIT_SEC  = 3'd3,
      ST_COMMIT    = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [LP_CW-1:0] r_cnt;
   logic [LP_CW-1:0] w_cnt_nxt;
   logic             r_prev_mode;
   logic             r_prev_inc;
   logic             r_prev_dec;
   logic [4:0]       r_hour;
   logic [5:0]       r_min;
   logic [5:0]       r_sec;
   logic [4:0]       w_hour_nxt;
   logic [5:0]       w_min_nxt;
   logic [5:0]       w_sec_nxt;

   logic w_mode_e;
   logic w_inc_e;
   logic w_dec_e;
   logic w_any_e;
   logic w_in_edit;
   logic w_timeout;
   logic w_step;

   assign w_mode_e  = btn_mode & ~r_prev_mode;
   assign w_inc_e   = btn_inc  & ~r_prev_inc;
   assign w_dec_e   = btn_dec  & ~r_prev_dec;
   assign w_any_e   = w_mode_e | w_inc_e | w_dec_e;
   assign w_in_edit = (r_state == ST_EDIT_HOUR) || (r_state == ST_EDIT_MIN) ||
                      (r_state == ST_EDIT_SEC);
   assign w_timeout = w_in_edit && !w_any_e && (r_cnt == LP_CNT_LAST);
   // Simultaneous inc+dec cancel; a mode edge swallows both.
   assign w_step    = w_in_edit && !w_mode_e && (w_inc_e ^ w_dec_e);

   function automatic logic [5:0] f_adj_ms(input logic [5:0] v, input logic up);
      logic [5:0] r;
      if (up) r = (v == LP_MS_MAX) ? 6'd0 : v + 6'd1;
      else    r = (v == 6'd0) ? LP_MS_MAX : v - 6'd1;
      return r;
   endfunction

   function automatic logic [4:0] f_adj_hour(input logic [4:0] v, input logic up);
      logic [4:0] r;
      if (up) r = (v == LP_HOUR_MAX) ? 5'd0 : v + 5'd1;
      else    r = (v == 5'd0) ? LP_HOUR_MAX : v - 5'd1;
      return r;
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_mode_e) w_state_nxt = ST_EDIT_HOUR;
         end
         ST_EDIT_HOUR: begin
            if (w_mode_e)       w_state_nxt = ST_EDIT_MIN;
            else if (w_timeout) w_state_nxt = ST_RUN;
         end
         ST_EDIT_MIN: begin
            if (w_mode_e)       w_state_nxt = ST_EDIT_SEC;
            else if (w_timeout) w_state_nxt = ST_RUN;
         end
         ST_EDIT_SEC: begin
            if (w_mode_e)       w_state_nxt = ST_COMMIT;
            else if (w_timeout) w_state_nxt = ST_RUN;
         end
         ST_COMMIT: w_state_nxt = ST_RUN;
         default:   w_state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      w_cnt_nxt = r_cnt + LP_CW'(1);
      if (!w_in_edit || w_any_e || w_timeout) w_cnt_nxt = '0;
   end

   always_comb begin
      w_hour_nxt = r_hour;
      w_min_nxt  = r_min;
      w_sec_nxt  = r_sec;
      if (r_state == ST_RUN && w_mode_e) begin
         // Out-of-range live values are replaced by 0 rather than carried into the editor.
         w_hour_nxt = (cur_hour > LP_HOUR_MAX) ? 5'd0 : cur_hour;
         w_min_nxt  = (cur_min  > LP_MS_MAX)   ? 6'd0 : cur_min;
         w_sec_nxt  = (cur_sec  > LP_MS_MAX)   ? 6'd0 : cur_sec;
      end else if (w_step) begin
         case (r_state)
            ST_EDIT_HOUR: w_hour_nxt = f_adj_hour(r_hour, w_inc_e);
            ST_EDIT_MIN:  w_min_nxt  = f_adj_ms(r_min, w_inc_e);
            ST_EDIT_SEC:  w_sec_nxt  = f_adj_ms(r_sec, w_inc_e);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_RUN;
         r_cnt       <= '0;
         r_prev_mode <= 1'b0;
         r_prev_inc  <= 1'b0;
         r_prev_dec  <= 1'b0;
         r_hour      <= 5'd0;
         r_min       <= 6'd0;
         r_sec       <= 6'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_prev_mode <= btn_mode;
         r_prev_inc  <= btn_inc;
         r_prev_dec  <= btn_dec;
         r_hour      <= w_hour_nxt;
         r_min       <= w_min_nxt;
         r_sec       <= w_sec_nxt;
      end
   end

   assign set     = (r_state == ST_COMMIT);
   assign editing = w_in_edit;
   assign hour_in = r_hour;
   assign min_in  = r_min;
   assign sec_in  = r_sec;

   always_comb begin
      field_sel = 2'd0;
      case (r_state)
         ST_EDIT_HOUR: field_sel = 2'd1;
         ST_EDIT_MIN:  field_sel = 2'd2;
         ST_EDIT_SEC:  field_sel = 2'd3;
         default:      field_sel = 2'd0;
      endcase
   end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Three-button time-setting sequencer for the Clock block (sec/min/hour counters with a `set` load strobe).
- Snapshots the running time and lets the user edit hour, then minute, then second.
- On commit, presents the edited values on `sec_in`/`min_in`/`hour_in` with a one-cycle `set` pulse.
- Sits between debounced front-panel buttons and the Clock instance.

Parameters:
TIMEOUT_CYCLES, 1000, cycles without a button edge in any edit state before abort; must be >= 2
HOUR_MAX, 23, largest legal hour value (hours wrap HOUR_MAX <-> 0)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
btn_mode  input  1  debounced level; rising edge advances edit field
btn_inc  input  1  debounced level; rising edge increments selected field
btn_dec  input  1  debounced level; rising edge decrements selected field
cur_sec  input  6  live seconds from Clock sec_out
cur_min  input  6  live minutes from Clock min_out
cur_hour  input  5  live hours from Clock hour_out
set  output  1  load strobe to Clock, one-cycle pulse
sec_in  output  6  edited seconds to Clock
min_in  output  6  edited minutes to Clock
hour_in  output  5  edited hours to Clock
editing  output  1  high in EDIT_HOUR/EDIT_MIN/EDIT_SEC
field_sel  output  2  0 none, 1 hour, 2 min, 3 sec (for display blink)

Behaviour:
- Reset (async, immediate): state RUN; set=0, sec_in=min_in=hour_in=0, editing=0, field_sel=0; timeout counter 0; button history regs 0.
- Edge detect: per button, prev reg holds last-cycle level; edge = level & ~prev. An edge present before rising edge N acts at edge N. A held button yields exactly one edge.
- States: RUN, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT.
- RUN:
  - mode edge -> EDIT_HOUR. Same edge snapshots cur_hour/cur_min/cur_sec into edit regs.
  - Snapshot clamping: any field above its maximum (hour > HOUR_MAX, min > 59, sec > 59) loads 0.
  - inc/dec ignored.
- EDIT_HOUR/EDIT_MIN/EDIT_SEC:
  - mode edge -> next state, in order EDIT_HOUR -> EDIT_MIN -> EDIT_SEC -> COMMIT.
  - inc edge: selected field +1; wraps HOUR_MAX->0 for hours, 59->0 for min/sec.
  - dec edge: selected field -1; wraps 0->HOUR_MAX for hours, 0->59 for min/sec.
  - inc and dec edges together: no change.
  - mode edge together with inc/dec: mode wins, inc/dec dropped.
- Timeout:
  - Counter clears on entering any edit state and on any button edge in an edit state; otherwise it increments.
  - When counter == TIMEOUT_CYCLES-1 with no edge that cycle: -> RUN, no set pulse, edit regs keep their values.
- COMMIT:
  - Lasts exactly one cycle; set=1 (Moore, decoded from state); then -> RUN unconditionally.
  - All buttons ignored in COMMIT.
  - sec_in/min_in/hour_in are stable the cycle before, during, and after set.
- Outputs:
  - sec_in/min_in/hour_in always reflect the edit regs and hold their last value in RUN.
  - editing and field_sel are decoded from state.
- Reset during any state, including COMMIT: immediate return to reset values; no set pulse completes.
- All arithmetic is at field width; wrap is explicit compare, not modulo-2^n.

Test Plan:
1. Reset, cur=01:58:62, press mode -> editing=1, field_sel=1; hour_in=1, min_in=58, sec_in=0 (62 clamped).
2. In EDIT_HOUR at 23: one inc -> hour_in=0. Then one dec -> hour_in=23. Hold inc high 50 cycles -> exactly one increment.
3. Full sequence from 10:20:30: mode; inc x2; mode; dec x21 (20->59 wrap); mode; inc; mode -> set high exactly one cycle with 12:59:31 on outputs; editing=0 next cycle.
4. TIMEOUT_CYCLES=8: enter edit, apply no buttons -> return to RUN after 8 cycles, set never asserted. An inc at cycle 5 restarts the count.
5. Simultaneous edges: inc+dec in EDIT_MIN -> min unchanged. mode+inc in EDIT_MIN -> EDIT_SEC, min unchanged.
6. Assert reset during COMMIT cycle -> set drops immediately, state RUN, all outputs 0.
